// File: rtl/pic_pkg.sv
// Shared types and constants for the interrupt acknowledge sequencer.
// Priority rank helper maps a level to its distance below the top slot.
package pic_pkg;

    localparam int IR_W  = 8;
    localparam int LVL_W = 3;

    localparam logic [LVL_W-1:0] SPURIOUS_DEF = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        WAIT1,
        ACK1,
        WAIT2,
        ACK2
    } pic_state_t;

    // 0 = highest priority, 7 = lowest, for a given lowest-priority level
    function automatic logic [LVL_W-1:0] prio_rank(
        input logic [LVL_W-1:0] lvl,
        input logic [LVL_W-1:0] low
    );
        return lvl - low - 3'd1;
    endfunction

endpackage

// File: rtl/priority_resolver.sv
// Circular priority pick: scans from low_prio+1 (highest) round to low_prio.
// Returns the highest-priority set level and whether any bit was set.
module priority_resolver
    import pic_pkg::*;
(
    input  logic [IR_W-1:0]  vec,
    input  logic [LVL_W-1:0] low_prio,
    output logic [LVL_W-1:0] lvl,
    output logic             valid
);

    always_comb begin
        logic [LVL_W-1:0] idx;
        idx   = '0;
        lvl   = '0;
        valid = 1'b0;
        // Walk lowest to highest so the last hit is the winner
        for (int k = IR_W - 1; k >= 0; k--) begin
            idx = low_prio + LVL_W'(k) + 3'd1;
            if (vec[idx]) begin
                lvl   = idx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/int_ack_sequencer.sv
// 8259-style INTA sequencer: priority, ISR tracking, vector output, EOI.
// Define INT_ACK_ROTATE_EN to enable rotate-on-EOI via ROT.
module int_ack_sequencer
    import pic_pkg::*;
#(
    parameter logic [LVL_W-1:0] SPURIOUS_LVL = SPURIOUS_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [IR_W-1:0]   IRR,
    input  logic [IR_W-1:0]   IMR,
    input  logic [4:0]        VEC_BASE,
    input  logic              AEOI,
    input  logic              ROT,
    input  logic              EOI_STB,
    input  logic              SEOI_STB,
    input  logic [LVL_W-1:0]  SEOI_LVL,
    input  logic              INTA_,
    output logic              INT,
    output logic [IR_W-1:0]   ISR,
    output logic [IR_W-1:0]   CLR_IRR,
    output logic [7:0]        DATA_OUT,
    output logic              DATA_OE,
    output logic [1:0]        INTA_COUNT
);

    pic_state_t       state_q, state_d;
    logic             int_q, int_d;
    logic [IR_W-1:0]  isr_q, isr_d;
    logic [IR_W-1:0]  clr_q, clr_d;
    logic [7:0]       dout_q, dout_d;
    logic             oe_q, oe_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [LVL_W-1:0] low_q, low_d;
    logic             inta_q;
    logic [LVL_W-1:0] win_q, win_d;
    logic             spur_q, spur_d;

    logic [LVL_W-1:0] cand_lvl, top_lvl;
    logic             cand_vld, top_vld;
    logic             eligible, fall, rise;
    logic [IR_W-1:0]  set_mask, clr_mask;
    logic             rot_hit;
    logic [LVL_W-1:0] rot_lvl;

    priority_resolver u_req (
        .vec      (IRR & ~IMR),
        .low_prio (low_q),
        .lvl      (cand_lvl),
        .valid    (cand_vld)
    );

    priority_resolver u_isr (
        .vec      (isr_q),
        .low_prio (low_q),
        .lvl      (top_lvl),
        .valid    (top_vld)
    );

    assign eligible = cand_vld &&
        (!top_vld ||
         (prio_rank(cand_lvl, low_q) < prio_rank(top_lvl, low_q)));

    assign fall = inta_q & ~INTA_;
    assign rise = ~inta_q & INTA_;

    always_comb begin
        state_d  = state_q;
        int_d    = int_q;
        clr_d    = '0;
        dout_d   = dout_q;
        oe_d     = oe_q;
        cnt_d    = cnt_q;
        win_d    = win_q;
        spur_d   = spur_q;
        set_mask = '0;
        clr_mask = '0;
        rot_hit  = 1'b0;
        rot_lvl  = low_q;

        // Specific EOI takes precedence over a coincident non-specific one
        if (SEOI_STB) begin
            clr_mask[SEOI_LVL] = 1'b1;
            rot_hit            = 1'b1;
            rot_lvl            = SEOI_LVL;
        end else if (EOI_STB && top_vld) begin
            clr_mask[top_lvl] = 1'b1;
            rot_hit           = 1'b1;
            rot_lvl           = top_lvl;
        end

        unique case (state_q)
            IDLE: begin
                if (eligible) begin
                    int_d   = 1'b1;
                    state_d = WAIT1;
                end
            end
            WAIT1: begin
                int_d = 1'b1;
                if (fall) begin
                    int_d   = 1'b0;
                    cnt_d   = 2'd1;
                    state_d = ACK1;
                    if (eligible) begin
                        win_d              = cand_lvl;
                        spur_d             = 1'b0;
                        set_mask[cand_lvl] = 1'b1;
                        clr_d[cand_lvl]    = 1'b1;
                    end else begin
                        win_d  = SPURIOUS_LVL;
                        spur_d = 1'b1;
                    end
                end
            end
            ACK1: begin
                if (rise)
                    state_d = WAIT2;
            end
            WAIT2: begin
                if (fall) begin
                    dout_d  = {VEC_BASE, win_q};
                    oe_d    = 1'b1;
                    cnt_d   = 2'd2;
                    state_d = ACK2;
                end
            end
            ACK2: begin
                if (rise) begin
                    oe_d    = 1'b0;
                    cnt_d   = 2'd0;
                    state_d = IDLE;
                    if (AEOI && !spur_q) begin
                        clr_mask[win_q] = 1'b1;
                        rot_hit         = 1'b1;
                        rot_lvl         = win_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        isr_d = (isr_q & ~clr_mask) | set_mask;

`ifdef INT_ACK_ROTATE_EN
        low_d = (ROT && rot_hit) ? rot_lvl : low_q;
`else
        low_d = 3'd7;
`endif
    end

`ifndef INT_ACK_ROTATE_EN
    logic unused_rot;
    assign unused_rot = ^{ROT, rot_hit, rot_lvl};
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            int_q   <= 1'b0;
            isr_q   <= '0;
            clr_q   <= '0;
            dout_q  <= '0;
            oe_q    <= 1'b0;
            cnt_q   <= 2'd0;
            low_q   <= 3'd7;
            inta_q  <= 1'b1;
            win_q   <= '0;
            spur_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            int_q   <= int_d;
            isr_q   <= isr_d;
            clr_q   <= clr_d;
            dout_q  <= dout_d;
            oe_q    <= oe_d;
            cnt_q   <= cnt_d;
            low_q   <= low_d;
            inta_q  <= INTA_;
            win_q   <= win_d;
            spur_q  <= spur_d;
        end
    end

    assign INT        = int_q;
    assign ISR        = isr_q;
    assign CLR_IRR    = clr_q;
    assign DATA_OUT   = dout_q;
    assign DATA_OE    = oe_q;
    assign INTA_COUNT = cnt_q;

endmodule

// File: doc/int_ack_sequencer.md
INT_ACK_SEQUENCER -- requirements
Module: int_ack_sequencer

Interface
REQ-001 SHALL have parameter SPURIOUS_LVL, default 3'd7, level reported when no request survives to the first INTA.
REQ-002 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port IRR  input  8  latched interrupt requests, bit n = IRn.
REQ-005 SHALL have port IMR  input  8  interrupt mask, 1 = masked.
REQ-006 SHALL have port VEC_BASE  input  5  vector bits T7..T3 from ICW2.
REQ-007 SHALL have port AEOI  input  1  auto-EOI mode.
REQ-008 SHALL have port ROT  input  1  rotate-on-EOI mode.
REQ-009 SHALL have port EOI_STB  input  1  one-cycle non-specific EOI.
REQ-010 SHALL have port SEOI_STB  input  1  one-cycle specific EOI.
REQ-011 SHALL have port SEOI_LVL  input  3  level for specific EOI.
REQ-012 SHALL have port INTA_  input  1  CPU acknowledge, active-low, synchronised to CLK.
REQ-013 SHALL have port INT  output  1  interrupt request to CPU.
REQ-014 SHALL have port ISR  output  8  in-service register.
REQ-015 SHALL have port CLR_IRR  output  8  one-hot, one-cycle IRR clear pulse.
REQ-016 SHALL have port DATA_OUT  output  8  vector byte {VEC_BASE, level}.
REQ-017 SHALL have port DATA_OE  output  1  vector drive enable.
REQ-018 SHALL have port INTA_COUNT  output  2  INTA pulses seen in current sequence (0..2).

Function
REQ-019 Eligible set SHALL be IRR & ~IMR; a candidate is eligible only if strictly higher priority than every set ISR bit.
REQ-020 Priority SHALL be circular from LOW_PRIO+1 (highest) to LOW_PRIO (lowest); LOW_PRIO resets to 7, giving IR0 highest.
REQ-021 FSM states SHALL be IDLE, WAIT1, ACK1, WAIT2, ACK2.
REQ-022 IDLE: if an eligible candidate exists, register INT=1 next cycle and go WAIT1 (1-cycle latency).
REQ-023 WAIT1: INT held 1; on INTA_ falling edge (previous sample 1, current 0) latch winner, set ISR[winner], pulse CLR_IRR[winner] one cycle, INT=0, INTA_COUNT=1, go ACK1.
REQ-024 If no candidate is eligible at the first falling edge, winner SHALL be SPURIOUS_LVL with no ISR set and no CLR_IRR pulse.
REQ-025 ACK1: on INTA_ rising edge go WAIT2.
REQ-026 WAIT2: on INTA_ falling edge DATA_OUT={VEC_BASE, winner}, DATA_OE=1, INTA_COUNT=2, go ACK2.
REQ-027 ACK2: on INTA_ rising edge DATA_OE=0, INTA_COUNT=0; if AEOI and not spurious, clear ISR[winner]; go IDLE.
REQ-028 Non-specific EOI SHALL clear the highest-priority set ISR bit; no-op if ISR=0.
REQ-029 Specific EOI SHALL clear ISR[SEOI_LVL]; if both strobes coincide, the specific EOI wins.
REQ-030 EOI and ISR set in the same cycle SHALL apply clear to the old ISR, then OR in the new bit.
REQ-031 INT SHALL stay 1 in WAIT1 even if the request withdraws (spurious path covers it).

Reset
REQ-032 RST SHALL force, on the next edge and from any state: state IDLE, INT 0, ISR 0, CLR_IRR 0, DATA_OUT 0, DATA_OE 0, INTA_COUNT 0, LOW_PRIO 7, INTA_ history 1.

Configuration
REQ-033 Macro INT_ACK_ROTATE_EN defined: when ROT=1, any EOI (including AEOI) SHALL set LOW_PRIO to the cleared level.
REQ-034 INT_ACK_ROTATE_EN undefined: ROT SHALL be ignored and LOW_PRIO held at 7.

Structure
REQ-035 Shared package pic_pkg SHALL hold the FSM state typedef, IR_W=8, LVL_W=3 and the default spurious level.
REQ-036 Combinational sub-module priority_resolver SHALL return highest set bit and valid flag given an 8-bit vector and LOW_PRIO.

Verification
REQ-037 IRR=0x24, IMR=0, VEC_BASE=5'b00100, two INTA_ pulses -> INT falls after first, ISR=0x04, CLR_IRR=0x04, DATA_OUT=0x22.
REQ-038 ISR=0x04 set, IRR=0x08 -> INT stays 0; raise IRR=0x01 -> INT=1, nested ISR=0x05 after ack.
REQ-039 IRR=0x10, drop IRR before first INTA_ -> DATA_OUT={VEC_BASE,3'd7}, ISR unchanged.
REQ-040 AEOI=1, IRR=0x02 full ack -> ISR returns 0x00 at second INTA_ rise.
REQ-041 INT_ACK_ROTATE_EN, ROT=1, ISR=0x08, EOI_STB -> ISR=0, LOW_PRIO=3, next IRR=0x11 grants IR4.
REQ-042 RST asserted in WAIT2 -> next cycle all outputs at reset values, INTA_COUNT=0.
